step_ctrl: RTL and testbench

Execution controller that sits directly upstream of the single-cycle processor. It converts the board push-buttons into qualified advance pulses for the processor datapath.
- cpu_step is a one-cycle enable. The processor's PC and REG/DMEM write paths advance only on SYS_clk edges where cpu_step=1. No clock gating.
- Modes: manual single-step, or free-run at a selectable divided rate.
- Run mode halts on a PC breakpoint.
- Keeps a retired-instruction counter for the LED/7-segment debug mux.

---
 rtl/step_ctrl_pkg.sv | 12 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/step_ctrl.sv | 119 +++++++++++
 tb/tb_step_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the processor execution controller.
package step_ctrl_pkg;

    localparam int RUN_DIV_W = 3;

    typedef enum logic [1:0] {
        MODE_STEP   = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_BPHALT = 2'd2
    } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-FF synchroniser, debounce counter, press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] cnt;

    // Counter runs only while the synchronised input disagrees with the
    // accepted level; any return to the accepted level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Converts debounced buttons into one-cycle cpu_step enables: manual step,
// divided free-run, and breakpoint halt, plus a retired-step counter.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_BASE_DIV    = 50000,
    parameter int DB_W            = 20
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    input  logic                 btn_step_n,
    input  logic                 btn_run_n,
    input  logic [RUN_DIV_W-1:0] run_div,
    input  logic                 bp_enable,
    input  logic [31:0]          bp_addr,
    input  logic [31:0]          cpu_pc,
    output logic                 cpu_step,
    output logic [1:0]           mode,
    output logic                 halted_bp,
    output logic [31:0]          step_count
);

    logic        step_press;
    logic        run_press;
    mode_e       state_q, state_d;
    logic [31:0] div_q, div_d;
    logic        step_q, step_d;
    logic [31:0] step_cnt_q;
    logic [31:0] period_m1;
    logic        step_req;
    logic        bp_hit;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_step (
        .clk   (SYS_clk),
        .rst_n (SYS_reset),
        .btn_n (btn_step_n),
        .press (step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_run (
        .clk   (SYS_clk),
        .rst_n (SYS_reset),
        .btn_n (btn_run_n),
        .press (run_press)
    );

    // Compare with >= so lowering run_div mid-count fires on the next cycle.
    assign period_m1 = (32'(RUN_BASE_DIV) << run_div) - 32'd1;
    assign step_req  = (div_q >= period_m1);
    assign bp_hit    = bp_enable && (cpu_pc == bp_addr);

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q    <= MODE_STEP;
            div_q      <= '0;
            step_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            step_q  <= step_d;
            if (step_d) step_cnt_q <= step_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        case (state_q)
            MODE_STEP: begin
                if (run_press) begin
                    state_d = MODE_RUN;
                    div_d   = '0;
                end
            end
            MODE_RUN: begin
                if (run_press) begin
                    state_d = MODE_STEP;
                    div_d   = '0;
                end else if (step_req) begin
                    div_d = '0;
                    if (bp_hit) state_d = MODE_BPHALT;
                end else begin
                    div_d = div_q + 32'd1;
                end
            end
            MODE_BPHALT: begin
                if (run_press) begin
                    state_d = MODE_RUN;
                    div_d   = '0;
                end else if (step_press) begin
                    state_d = MODE_STEP;
                end
            end
            default: begin
                state_d = MODE_STEP;
                div_d   = '0;
            end
        endcase
    end

    // Run press always dominates a coincident step press or run-mode request.
    always_comb begin
        step_d = 1'b0;
        case (state_q)
            MODE_STEP:   step_d = step_press && !run_press;
            MODE_RUN:    step_d = !run_press && step_req && !bp_hit;
            MODE_BPHALT: step_d = run_press || step_press;
            default:     step_d = 1'b0;
        endcase
    end

    assign cpu_step   = step_q;
    assign mode       = state_q;
    assign halted_bp  = (state_q == MODE_BPHALT);
    assign step_count = step_cnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: expected step pulses (cycle, count) are queued
// from timing rules and popped by a monitor whenever cpu_step is seen.
module tb_step_ctrl;
    import step_ctrl_pkg::*;

    localparam int DC   = 4;
    localparam int BASE = 3;
    localparam int LAT  = DC + 3;   // raw press start -> cpu_step cycle

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_step_n = 1'b1;
    logic        btn_run_n = 1'b1;
    logic [2:0]  run_div = 3'd0;
    logic        bp_enable = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] cpu_pc;
    logic        cpu_step;
    logic [1:0]  mode;
    logic        halted_bp;
    logic [31:0] step_count;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    step_ctrl #(.DEBOUNCE_CYCLES(DC), .RUN_BASE_DIV(BASE), .DB_W(4)) dut (
        .SYS_clk    (clk),
        .SYS_reset  (rst_n),
        .btn_step_n (btn_step_n),
        .btn_run_n  (btn_run_n),
        .run_div    (run_div),
        .bp_enable  (bp_enable),
        .bp_addr    (bp_addr),
        .cpu_pc     (cpu_pc),
        .cpu_step   (cpu_step),
        .mode       (mode),
        .halted_bp  (halted_bp),
        .step_count (step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Processor stand-in: PC advances by 4 on each enabled edge.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cpu_pc <= 32'd0;
        else if (cpu_step) cpu_pc <= cpu_pc + 32'd4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, wanted %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_step(input int c);
        exp_cnt = exp_cnt + 32'd1;
        exp_q.push_back('{c, exp_cnt});
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic hold_low(input bit s, input bit r, input int len);
        if (s) btn_step_n = 1'b0;
        if (r) btn_run_n = 1'b0;
        ncyc(len);
        btn_step_n = 1'b1;
        btn_run_n = 1'b1;
    endtask

    // Called on a run-mode pulse cycle k with period p: requests up to the
    // cycle before the run press lands still issue steps.
    task automatic stop_run(input int k, input int p);
        for (int j = p; j <= LAT - 1; j += p) expect_step(k + j);
        hold_low(1'b0, 1'b1, 8);
        chk("stop_mode", 32'(mode), 32'(MODE_STEP));
        ncyc(8);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_step === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_step: got pulse at cyc %0d, wanted none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("step_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("step_count", step_count, mon_e.cnt);
            end
        end
    end

    initial begin
        int N, T, P, H, nb, lo, hi, spent;

        ncyc(3);
        chk("rst_mode", 32'(mode), 32'(MODE_STEP));
        chk("rst_step", 32'(cpu_step), 32'd0);
        chk("rst_halted", 32'(halted_bp), 32'd0);
        chk("rst_count", step_count, 32'd0);
        rst_n = 1'b1;
        ncyc(6);

        // single manual step
        N = cyc;
        expect_step(N + LAT);
        hold_low(1'b1, 1'b0, $urandom_range(8, 12));
        ncyc(10);
        chk("t1_mode", 32'(mode), 32'(MODE_STEP));
        chk("t1_count", step_count, exp_cnt);

        // bounce with segments too short to accept, then a clean hold
        spent = 0;
        while (spent < 20) begin
            lo = $urandom_range(1, 3);
            hi = $urandom_range(1, 3);
            btn_step_n = 1'b0;
            ncyc(lo);
            btn_step_n = 1'b1;
            ncyc(hi);
            spent += lo + hi;
        end
        N = cyc;
        expect_step(N + LAT);
        hold_low(1'b1, 1'b0, 10);
        ncyc(10);
        chk("t2_count", step_count, exp_cnt);

        // free run, then a randomly slower rate
        run_div = 3'd0;
        N = cyc;
        T = N + LAT;
        expect_step(T + 3);
        expect_step(T + 6);
        hold_low(1'b0, 1'b1, 8);
        chk("t3_mode", 32'(mode), 32'(MODE_RUN));
        wait_until(T + 6);
        run_div = 3'($urandom_range(1, 2));
        P = BASE << run_div;
        for (int k = 1; k <= 3; k++) expect_step(T + 6 + k * P);
        wait_until(T + 6 + 3 * P);
        chk("t3_mode_run", 32'(mode), 32'(MODE_RUN));
        stop_run(T + 6 + 3 * P, P);

        // breakpoint halt; first exit by run press, second by step press
        for (int it = 0; it < 2; it++) begin
            run_div = 3'd0;
            bp_enable = 1'b1;
            nb = $urandom_range(1, 4);
            bp_addr = cpu_pc + 32'(4 * nb);
            N = cyc;
            T = N + LAT;
            for (int k = 1; k <= nb; k++) expect_step(T + 3 * k);
            hold_low(1'b0, 1'b1, 8);
            H = T + 3 * (nb + 1);
            wait_until(H);
            chk("bp_mode", 32'(mode), 32'(MODE_BPHALT));
            chk("bp_halted", 32'(halted_bp), 32'd1);
            ncyc(10);
            chk("bp_hold_mode", 32'(mode), 32'(MODE_BPHALT));
            N = cyc;
            expect_step(N + LAT);
            if (it == 0) begin
                for (int k = 1; k <= 4; k++) expect_step(N + LAT + 3 * k);
                hold_low(1'b0, 1'b1, 8);
                chk("bp_run_halted", 32'(halted_bp), 32'd0);
                chk("bp_run_mode", 32'(mode), 32'(MODE_RUN));
                wait_until(N + LAT + 12);
                stop_run(N + LAT + 12, 3);
            end else begin
                hold_low(1'b1, 1'b0, 8);
                chk("bp_step_mode", 32'(mode), 32'(MODE_STEP));
                chk("bp_step_halted", 32'(halted_bp), 32'd0);
                ncyc(8);
            end
        end

        // breakpoint matching PC is ignored for manual steps
        bp_addr = cpu_pc;
        N = cyc;
        expect_step(N + LAT);
        hold_low(1'b1, 1'b0, 8);
        chk("bp_step_scope", 32'(mode), 32'(MODE_STEP));
        ncyc(8);
        bp_enable = 1'b0;

        // simultaneous presses: run wins, no step
        run_div = 3'd0;
        N = cyc;
        T = N + LAT;
        expect_step(T + 3);
        expect_step(T + 6);
        expect_step(T + 9);
        hold_low(1'b1, 1'b1, 8);
        chk("both_mode", 32'(mode), 32'(MODE_RUN));
        wait_until(T + 9);
        stop_run(T + 9, 3);

        // counter wrap
        force dut.step_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.step_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        N = cyc;
        expect_step(N + LAT);
        hold_low(1'b1, 1'b0, 8);
        chk("wrap_count", step_count, 32'd0);
        ncyc(8);

        // reset in the middle of a run period
        run_div = 3'd1;
        N = cyc;
        T = N + LAT;
        expect_step(T + 6);
        hold_low(1'b0, 1'b1, 8);
        wait_until(T + 8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_step", 32'(cpu_step), 32'd0);
        chk("mid_rst_mode", 32'(mode), 32'(MODE_STEP));
        chk("mid_rst_halted", 32'(halted_bp), 32'd0);
        chk("mid_rst_count", step_count, 32'd0);
        exp_cnt = 32'd0;
        ncyc(2);
        rst_n = 1'b1;
        ncyc(20);
        chk("post_rst_mode", 32'(mode), 32'(MODE_STEP));

        chk("missing_steps", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
